dcache_refill_unit: RTL and testbench
=====================================

Name: dcache_refill_unit

Overview:
- Miss-handling stage directly upstream of the D-cache data LUTRAM (128-bit line, 16-byte strobe, 0-latency read).
- On a miss: writes back a dirty victim line, burst-reads the new line from the memory bus, assembles it, and writes it into the data RAM in one cycle.
- Sits between the D-cache controller (miss request) and the AXI-facing bus bridge (burst request/data channels).

Parameters:
- IDX_BITS, Dcache_index_bits (from package), data RAM index width.
- WORDS_PER_LINE, 4, 32-bit words per 128-bit line; fixed, not overridable.
- TAG_BITS, 32-IDX_BITS-4, tag width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- miss_valid  in  1  miss request
- miss_ready  out  1  unit idle, accepts request
- miss_index  in  IDX_BITS  line index
- miss_tag  in  TAG_BITS  new line tag
- miss_word  in  2  requested word offset
- victim_dirty  in  1  victim needs writeback
- victim_tag  in  TAG_BITS  victim tag
- ram_addr  out  IDX_BITS  data RAM address
- ram_strobe  out  16  data RAM byte write enables
- ram_wdata  out  128  data RAM write data
- ram_rdata  in  128  data RAM read data (combinational)
- mreq_valid  out  1  burst request valid
- mreq_ready  in  1  burst request accepted
- mreq_write  out  1  1=writeback, 0=refill
- mreq_addr  out  32  line-aligned address
- mw_valid  out  1  write beat valid
- mw_ready  in  1  write beat accepted
- mw_data  out  32  write beat data
- mw_last  out  1  final write beat
- mr_valid  in  1  read beat valid (unit always accepts in RD_DATA)
- mr_data  in  32  read beat data
- mr_last  in  1  final read beat
- done  out  1  one-cycle pulse, line installed

Behaviour:
- FSM: IDLE, WB_REQ, WB_DATA, RD_REQ, RD_DATA, FILL, DONE.
- Reset: state=IDLE, miss_ready=1, all other outputs 0, beat counter=0.
- IDLE:
  - miss_ready=1; request latched when miss_valid && miss_ready.
  - Next state WB_REQ if victim_dirty, else RD_REQ.
- WB_REQ:
  - ram_addr=latched index; ram_strobe=0.
  - On entry, ram_rdata captured into a 128-bit writeback buffer.
  - mreq_valid=1, mreq_write=1, mreq_addr={victim_tag, index, 4'b0}.
  - Hold all mreq fields stable until mreq_ready; then go to WB_DATA.
- WB_DATA:
  - Beats word0..word3 sent in ascending order; mw_data=buffer[32*cnt+:32].
  - Counter advances only on mw_valid&&mw_ready.
  - mw_last=1 when cnt==3; after the last beat is accepted, go to RD_REQ.
- RD_REQ: mreq_write=0, mreq_addr={miss_tag, index, 4'b0}; hold until mreq_ready, then go to RD_DATA.
- RD_DATA:
  - Each mr_valid beat is written into line buffer slot cnt; cnt increments mod 4.
  - On mr_last, go to FILL.
  - mr_last arriving with cnt!=3 is a protocol error: go to FILL anyway; unfilled slots hold 0.
- FILL:
  - Exactly one cycle: ram_addr=index, ram_strobe=16'hFFFF, ram_wdata=line buffer.
  - Next state DONE.
- DONE: done=1 for one cycle, cnt=0, line buffer cleared; then IDLE.
- ram_strobe is 0 in every state except FILL.
- Latency, clean miss with zero-wait bus: request accept → done = 1 (RD_REQ) + 4 beats + 1 (FILL) + 1 = 7 cycles. A dirty miss adds 1 + 4 cycles.
- miss_valid outside IDLE is ignored (miss_ready=0).
- Reset mid-operation returns to IDLE next cycle.
  - No RAM write occurs in that reset cycle.
  - Any in-flight bus transaction is abandoned; the bus bridge is reset on the same signal.

Optional Feature:
- Macro: DCACHE_REFILL_BYPASS_EN.
- Defined: extra outputs byp_valid (1 bit) and byp_data (32 bits).
  - byp_valid pulses for one cycle in the RD_DATA cycle where mr_valid && cnt==miss_word.
  - byp_data=mr_data in that cycle, so the pipeline restarts before FILL.
- Not defined: ports absent; the requester waits for done.

Decomposition:
- Package dcache_pkg holds Dcache_index_bits, TAG_BITS and the state enum refill_state_t.
- Sub-module dcache_line_buffer: 4×32 register file with slot write and full 128-bit read.
  - Used for both the writeback buffer and the refill buffer.

Test Plan:
- Clean miss: index=5, tag=0x1234, zero-wait bus, beats 0xA0..0xA3. Required: mreq_addr={0x1234, 5, 0}; one FILL cycle with strobe=FFFF and wdata=0x000000A3_000000A2_000000A1_000000A0; done pulses 7 cycles after accept.
- Dirty miss: ram_rdata=0x44..._11 at index 2, victim_tag=0x7. Required: write request at {0x7, 2, 0}; beats 0x11, 0x22, 0x33, 0x44 with mw_last on the 4th; then the read request.
- Backpressure: mreq_ready low 3 cycles, mw_ready toggling. Required: mreq_addr and mw_data stable while stalled; no beat skipped or duplicated.
- Reset asserted mid-RD_DATA after 2 beats. Required: next cycle state=IDLE, miss_ready=1, ram_strobe never nonzero.
- Bypass (macro on): miss_word=2. Required: byp_valid exactly once, on the 3rd read beat, with byp_data equal to that beat.
- Early mr_last on the 2nd beat. Required: FILL writes slots 0–1 from the bus and slots 2–3 as 0.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared sizing and state encoding for the D-cache miss path.
//   Dcache_index_bits : data RAM index width
//   IDX_BITS          : alias of Dcache_index_bits used for port widths
//   WORDS_PER_LINE    : 32-bit words per 128-bit line (fixed)
//   TAG_BITS          : tag width for a 32-bit address with 16-byte lines
//   refill_state_t    : refill FSM states
package dcache_pkg;

    localparam int unsigned Dcache_index_bits = 6;
    localparam int unsigned IDX_BITS          = Dcache_index_bits;
    localparam int unsigned WORDS_PER_LINE    = 4;
    localparam int unsigned TAG_BITS          = 32 - Dcache_index_bits - 4;

    typedef enum logic [2:0] {
        StIdle,
        StWbReq,
        StWbData,
        StRdReq,
        StRdData,
        StFill,
        StDone
    } refill_state_t;

endpackage

// File: rtl/dcache_line_buffer.sv
// dcache_line_buffer: 4 x 32-bit register file holding one cache line.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (clears all words)
//   clr         : synchronous clear of all words
//   load_en     : load the whole line from load_data
//   load_data   : 128-bit line to load
//   wr_en       : write one word
//   wr_slot     : word index for wr_en
//   wr_data     : word to write
//   line        : current line contents, word 0 in bits [31:0]
module dcache_line_buffer (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load_en,
    input  logic [127:0] load_data,
    input  logic         wr_en,
    input  logic [1:0]   wr_slot,
    input  logic [31:0]  wr_data,
    output logic [127:0] line
);

    logic [31:0] word_q [4];

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            for (int i = 0; i < 4; i++) begin
                word_q[i] <= '0;
            end
        end else if (load_en) begin
            for (int i = 0; i < 4; i++) begin
                word_q[i] <= load_data[32*i +: 32];
            end
        end else if (wr_en) begin
            word_q[wr_slot] <= wr_data;
        end
    end

    always_comb begin
        line = '0;
        for (int i = 0; i < 4; i++) begin
            line[32*i +: 32] = word_q[i];
        end
    end

endmodule

// File: rtl/dcache_refill_unit.sv
// dcache_refill_unit: D-cache miss handler. Writes back a dirty victim line,
// burst-reads the missing line and installs it in the data RAM in one cycle.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   miss_*                          : miss request from the cache controller
//   victim_dirty, victim_tag        : victim line state for writeback
//   ram_addr/strobe/wdata, ram_rdata: data RAM port (0-latency read)
//   mreq_*                          : burst request to the bus bridge
//   mw_*                            : writeback beats to the bus bridge
//   mr_*                            : refill beats from the bus bridge
//   done                            : one-cycle pulse when the line is installed
// Build option: define DCACHE_REFILL_BYPASS_EN to add byp_valid/byp_data, which
// forward the requested word as it arrives so the pipeline can restart early.
module dcache_refill_unit
    import dcache_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                miss_valid,
    output logic                miss_ready,
    input  logic [IDX_BITS-1:0] miss_index,
    input  logic [TAG_BITS-1:0] miss_tag,
    input  logic [1:0]          miss_word,
    input  logic                victim_dirty,
    input  logic [TAG_BITS-1:0] victim_tag,
    output logic [IDX_BITS-1:0] ram_addr,
    output logic [15:0]         ram_strobe,
    output logic [127:0]        ram_wdata,
    input  logic [127:0]        ram_rdata,
    output logic                mreq_valid,
    input  logic                mreq_ready,
    output logic                mreq_write,
    output logic [31:0]         mreq_addr,
    output logic                mw_valid,
    input  logic                mw_ready,
    output logic [31:0]         mw_data,
    output logic                mw_last,
    input  logic                mr_valid,
    input  logic [31:0]         mr_data,
    input  logic                mr_last,
    output logic                done
`ifdef DCACHE_REFILL_BYPASS_EN
    ,
    output logic                byp_valid,
    output logic [31:0]         byp_data
`endif
);

    refill_state_t       state;
    logic [TAG_BITS-1:0] tag_q;
    logic [1:0]          cnt;
    logic                wb_loaded;
    logic [127:0]        wb_line;
    logic [127:0]        rd_line;
    logic                buf_clr;
    logic                wb_load;
    logic                rd_wr_en;
`ifdef DCACHE_REFILL_BYPASS_EN
    logic [1:0]          word_q;
`endif

    assign buf_clr  = (state == StDone);
    // RAM read is combinational; grab the victim only on the first WB_REQ cycle.
    assign wb_load  = (state == StWbReq) && !wb_loaded;
    assign rd_wr_en = (state == StRdData) && mr_valid;

    dcache_line_buffer u_wb_buf (
        .clk       (clk),
        .reset     (reset),
        .clr       (buf_clr),
        .load_en   (wb_load),
        .load_data (ram_rdata),
        .wr_en     (1'b0),
        .wr_slot   (2'd0),
        .wr_data   (32'd0),
        .line      (wb_line)
    );

    dcache_line_buffer u_rd_buf (
        .clk       (clk),
        .reset     (reset),
        .clr       (buf_clr),
        .load_en   (1'b0),
        .load_data (128'd0),
        .wr_en     (rd_wr_en),
        .wr_slot   (cnt),
        .wr_data   (mr_data),
        .line      (rd_line)
    );

    // ram_addr doubles as the latched miss index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            miss_ready <= 1'b1;
            tag_q      <= '0;
            cnt        <= '0;
            wb_loaded  <= 1'b0;
            ram_addr   <= '0;
            mreq_valid <= 1'b0;
            mreq_write <= 1'b0;
            mreq_addr  <= '0;
            mw_valid   <= 1'b0;
            mw_last    <= 1'b0;
            done       <= 1'b0;
`ifdef DCACHE_REFILL_BYPASS_EN
            word_q     <= '0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (miss_valid) begin
                        ram_addr   <= miss_index;
                        tag_q      <= miss_tag;
`ifdef DCACHE_REFILL_BYPASS_EN
                        word_q     <= miss_word;
`endif
                        miss_ready <= 1'b0;
                        mreq_valid <= 1'b1;
                        if (victim_dirty) begin
                            state      <= StWbReq;
                            mreq_write <= 1'b1;
                            mreq_addr  <= {victim_tag, miss_index, 4'b0000};
                        end else begin
                            state      <= StRdReq;
                            mreq_write <= 1'b0;
                            mreq_addr  <= {miss_tag, miss_index, 4'b0000};
                        end
                    end
                end
                StWbReq: begin
                    wb_loaded <= 1'b1;
                    if (mreq_ready) begin
                        wb_loaded  <= 1'b0;
                        mreq_valid <= 1'b0;
                        mw_valid   <= 1'b1;
                        mw_last    <= 1'b0;
                        state      <= StWbData;
                    end
                end
                StWbData: begin
                    if (mw_ready) begin
                        cnt     <= cnt + 2'd1;
                        mw_last <= (cnt == 2'd2);
                        if (cnt == 2'd3) begin
                            mw_valid   <= 1'b0;
                            mw_last    <= 1'b0;
                            mreq_valid <= 1'b1;
                            mreq_write <= 1'b0;
                            mreq_addr  <= {tag_q, ram_addr, 4'b0000};
                            state      <= StRdReq;
                        end
                    end
                end
                StRdReq: begin
                    if (mreq_ready) begin
                        mreq_valid <= 1'b0;
                        state      <= StRdData;
                    end
                end
                StRdData: begin
                    if (mr_valid) begin
                        cnt <= cnt + 2'd1;
                        // An early last still installs the line; missing slots stay 0.
                        if (mr_last) begin
                            state <= StFill;
                        end
                    end
                end
                StFill: begin
                    done  <= 1'b1;
                    state <= StDone;
                end
                StDone: begin
                    done       <= 1'b0;
                    cnt        <= '0;
                    miss_ready <= 1'b1;
                    state      <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign mw_data    = mw_valid ? wb_line[32*cnt +: 32] : 32'd0;
    // Gated by reset so a reset landing on FILL cannot write the RAM.
    assign ram_strobe = (state == StFill && !reset) ? 16'hFFFF : 16'h0000;
    assign ram_wdata  = rd_line;

`ifdef DCACHE_REFILL_BYPASS_EN
    assign byp_valid = (state == StRdData) && mr_valid && (cnt == word_q);
    assign byp_data  = byp_valid ? mr_data : 32'd0;
`endif

endmodule

// File: tb/tb_dcache_refill_unit.sv
// tb_dcache_refill_unit: self-checking bench for dcache_refill_unit. A bus
// bridge and data RAM model drive the DUT; expected addresses, beats, lines and
// latencies are computed from the miss-handling rules.
module tb_dcache_refill_unit;
    import dcache_pkg::*;

    logic                clk;
    logic                reset;
    logic                miss_valid;
    logic                miss_ready;
    logic [IDX_BITS-1:0] miss_index;
    logic [TAG_BITS-1:0] miss_tag;
    logic [1:0]          miss_word;
    logic                victim_dirty;
    logic [TAG_BITS-1:0] victim_tag;
    logic [IDX_BITS-1:0] ram_addr;
    logic [15:0]         ram_strobe;
    logic [127:0]        ram_wdata;
    logic [127:0]        ram_rdata;
    logic                mreq_valid;
    logic                mreq_ready;
    logic                mreq_write;
    logic [31:0]         mreq_addr;
    logic                mw_valid;
    logic                mw_ready;
    logic [31:0]         mw_data;
    logic                mw_last;
    logic                mr_valid;
    logic [31:0]         mr_data;
    logic                mr_last;
    logic                done;
`ifdef DCACHE_REFILL_BYPASS_EN
    logic                byp_valid;
    logic [31:0]         byp_data;
`endif

    logic [127:0] ram_mem [2**IDX_BITS];
    assign ram_rdata = ram_mem[ram_addr];

    dcache_refill_unit dut (
        .clk          (clk),
        .reset        (reset),
        .miss_valid   (miss_valid),
        .miss_ready   (miss_ready),
        .miss_index   (miss_index),
        .miss_tag     (miss_tag),
        .miss_word    (miss_word),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag),
        .ram_addr     (ram_addr),
        .ram_strobe   (ram_strobe),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .mreq_valid   (mreq_valid),
        .mreq_ready   (mreq_ready),
        .mreq_write   (mreq_write),
        .mreq_addr    (mreq_addr),
        .mw_valid     (mw_valid),
        .mw_ready     (mw_ready),
        .mw_data      (mw_data),
        .mw_last      (mw_last),
        .mr_valid     (mr_valid),
        .mr_data      (mr_data),
        .mr_last      (mr_last),
        .done         (done)
`ifdef DCACHE_REFILL_BYPASS_EN
        ,
        .byp_valid    (byp_valid),
        .byp_data     (byp_data)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Observations of one miss transaction.
    int          obs_accepts, obs_acc_cyc, obs_done_cyc, obs_done_cnt;
    int          obs_wreq_cnt, obs_rreq_cnt, obs_rreq_wbeats, obs_fill_cnt, obs_unstable;
    int          obs_byp_cnt, obs_byp_beat;
    bit          obs_timeout;
    logic [31:0] obs_wreq_addr, obs_rreq_addr, obs_byp_data;
    logic [15:0] obs_fill_strobe;
    logic [IDX_BITS-1:0] obs_fill_addr;
    logic [127:0] obs_fill_data;
    logic [31:0] obs_wbeat [$];
    logic        obs_wlast [$];

    function automatic logic [31:0] line_addr(input logic [TAG_BITS-1:0] t,
                                              input logic [IDX_BITS-1:0] i);
        return (32'(t) << (IDX_BITS + 4)) + 32'(i) * 32'd16;
    endfunction

    // Line the RAM should receive when only the first n beats arrive.
    function automatic logic [127:0] expect_line(input logic [127:0] beats, input int n);
        logic [127:0] mask;
        mask = (n >= 4) ? {128{1'b1}} : ((128'd1 << (32 * n)) - 128'd1);
        return beats & mask;
    endfunction

    function automatic logic [TAG_BITS-1:0] rnd_tag();
        logic [31:0] r;
        r = $urandom;
        return r[TAG_BITS-1:0];
    endfunction

    function automatic logic [IDX_BITS-1:0] rnd_idx();
        logic [31:0] r;
        r = $urandom;
        return r[IDX_BITS-1:0];
    endfunction

    function automatic logic [127:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Bus bridge + RAM model for one miss. Inputs change on the falling edge and
    // outputs are sampled 1 time unit later; abort_beats >= 0 asserts reset after
    // that many refill beats and returns with reset still high.
    task automatic drive_miss(input logic [IDX_BITS-1:0] idx, input logic [TAG_BITS-1:0] tag,
                              input logic [1:0] word, input bit dirty,
                              input logic [TAG_BITS-1:0] vtag, input logic [127:0] rd_line,
                              input int nbeats, input int req_stall, input bit rnd_bus,
                              input bit hold_valid, input int abort_beats);
        int cyc, k, stall_left;
        bit accepted, rd_phase, req_pending, wb_pending, finished;
        logic [32:0] req_hold;
        logic [31:0] wb_hold;
        cyc = 0; k = 0; stall_left = req_stall;
        accepted = 0; rd_phase = 0; req_pending = 0; wb_pending = 0; finished = 0;
        req_hold = '0; wb_hold = '0;
        obs_accepts = 0; obs_acc_cyc = 0; obs_done_cyc = 0; obs_done_cnt = 0;
        obs_wreq_cnt = 0; obs_rreq_cnt = 0; obs_rreq_wbeats = 0; obs_fill_cnt = 0;
        obs_unstable = 0; obs_byp_cnt = 0; obs_byp_beat = -1; obs_timeout = 0;
        obs_wreq_addr = '0; obs_rreq_addr = '0; obs_byp_data = '0;
        obs_fill_strobe = '0; obs_fill_addr = '0; obs_fill_data = '0;
        obs_wbeat.delete();
        obs_wlast.delete();
        @(negedge clk);
        miss_valid = 1'b1; miss_index = idx; miss_tag = tag; miss_word = word;
        victim_dirty = dirty; victim_tag = vtag;
        while (!finished && cyc < 300) begin
            if (accepted) begin
                if (hold_valid) begin
                    miss_index = ~idx;
                    miss_tag   = ~tag;
                end else begin
                    miss_valid = 1'b0;
                end
            end
            mreq_ready = !(mreq_valid && stall_left > 0);
            mw_ready   = rnd_bus ? 1'($urandom_range(0, 1)) : 1'b1;
            mr_valid = 1'b0; mr_last = 1'b0; mr_data = $urandom;
            if (rd_phase && k == abort_beats) begin
                reset = 1'b1;
            end else if (rd_phase && k < nbeats && (!rnd_bus || $urandom_range(0, 1) == 1)) begin
                mr_valid = 1'b1;
                mr_data  = rd_line[32*k +: 32];
                mr_last  = (k == nbeats - 1);
            end
            #1;
            if (miss_valid && miss_ready) begin
                obs_accepts++;
                if (!accepted) begin
                    accepted    = 1;
                    obs_acc_cyc = cyc;
                end
            end
            if (ram_strobe != 16'h0000) begin
                obs_fill_cnt++;
                obs_fill_strobe = ram_strobe;
                obs_fill_addr   = ram_addr;
                obs_fill_data   = ram_wdata;
                for (int b = 0; b < 16; b++) begin
                    if (ram_strobe[b]) ram_mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
                end
            end
            if (mreq_valid) begin
                if (req_pending && {mreq_write, mreq_addr} != req_hold) obs_unstable++;
                if (mreq_ready) begin
                    req_pending = 0;
                    stall_left  = req_stall;
                    if (mreq_write) begin
                        obs_wreq_cnt++;
                        obs_wreq_addr = mreq_addr;
                    end else begin
                        obs_rreq_cnt++;
                        obs_rreq_addr   = mreq_addr;
                        obs_rreq_wbeats = obs_wbeat.size();
                        rd_phase        = 1;
                    end
                end else begin
                    req_pending = 1;
                    req_hold    = {mreq_write, mreq_addr};
                    stall_left--;
                end
            end
            if (mw_valid) begin
                if (wb_pending && mw_data != wb_hold) obs_unstable++;
                if (mw_ready) begin
                    obs_wbeat.push_back(mw_data);
                    obs_wlast.push_back(mw_last);
                    wb_pending = 0;
                end else begin
                    wb_pending = 1;
                    wb_hold    = mw_data;
                end
            end
`ifdef DCACHE_REFILL_BYPASS_EN
            if (byp_valid) begin
                obs_byp_cnt++;
                obs_byp_beat = k;
                obs_byp_data = byp_data;
            end
`endif
            if (mr_valid) k++;
            if (done) begin
                obs_done_cnt++;
                obs_done_cyc = cyc;
                finished = 1;
            end
            if (reset) finished = 1;
            cyc++;
            if (!finished) @(negedge clk);
        end
        if (!finished) obs_timeout = 1;
        if (!reset) begin
            @(negedge clk);
            miss_valid = 1'b0; mr_valid = 1'b0; mr_last = 1'b0;
            mw_ready = 1'b0; mreq_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; miss_valid = 1'b0; miss_index = '0; miss_tag = '0; miss_word = '0;
        victim_dirty = 1'b0; victim_tag = '0; mreq_ready = 1'b0; mw_ready = 1'b0;
        mr_valid = 1'b0; mr_data = '0; mr_last = 1'b0;
        for (int i = 0; i < 2**IDX_BITS; i++) ram_mem[i] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (miss_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_miss_ready got %b want 1", miss_ready);
        end
        n_checks++;
        if ({mreq_valid, mreq_write, mw_valid, mw_last, done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b want 00000",
                     {mreq_valid, mreq_write, mw_valid, mw_last, done});
        end
        n_checks++;
        if ({mreq_addr, mw_data, ram_strobe, ram_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_data got addr=%h mw=%h strb=%h ram=%h want all 0",
                     mreq_addr, mw_data, ram_strobe, ram_addr);
        end
        n_checks++;
        if (ram_wdata !== 128'd0) begin
            n_fail++; $display("FAIL reset_wdata got %h want 0", ram_wdata);
        end
    endtask

    task automatic test_clean_miss();
        logic [127:0] beats;
        logic [127:0] want;
        beats = 128'h000000A3_000000A2_000000A1_000000A0;
        drive_miss(6'd5, 22'h1234, 2'd0, 1'b0, '0, beats, 4, 0, 1'b0, 1'b0, -1);
        want = 128'h000000A3_000000A2_000000A1_000000A0;
        n_checks++;
        if (obs_timeout) begin n_fail++; $display("FAIL clean_timeout got 1 want 0"); end
        n_checks++;
        if (obs_rreq_addr !== 32'h0048D050 || obs_rreq_cnt != 1) begin
            n_fail++;
            $display("FAIL clean_rreq got %h x%0d want 0048d050 x1", obs_rreq_addr, obs_rreq_cnt);
        end
        n_checks++;
        if (obs_wreq_cnt != 0) begin
            n_fail++; $display("FAIL clean_no_wb got %0d want 0", obs_wreq_cnt);
        end
        n_checks++;
        if (obs_fill_cnt != 1 || obs_fill_strobe !== 16'hFFFF || obs_fill_addr !== 6'd5) begin
            n_fail++;
            $display("FAIL clean_fill got n=%0d strb=%h addr=%0d want n=1 strb=ffff addr=5",
                     obs_fill_cnt, obs_fill_strobe, obs_fill_addr);
        end
        n_checks++;
        if (obs_fill_data !== want) begin
            n_fail++; $display("FAIL clean_wdata got %h want %h", obs_fill_data, want);
        end
        n_checks++;
        if (obs_done_cyc - obs_acc_cyc != 7 || obs_done_cnt != 1) begin
            n_fail++;
            $display("FAIL clean_latency got %0d want 7", obs_done_cyc - obs_acc_cyc);
        end
    endtask

    task automatic test_clean_random();
        for (int it = 0; it < 4; it++) begin
            logic [IDX_BITS-1:0] idx;
            logic [TAG_BITS-1:0] tag;
            logic [127:0] beats;
            idx = rnd_idx(); tag = rnd_tag(); beats = rnd_line();
            drive_miss(idx, tag, 2'($urandom_range(0, 3)), 1'b0, rnd_tag(), beats, 4, 0,
                       1'b0, 1'b0, -1);
            n_checks++;
            if (obs_rreq_addr !== line_addr(tag, idx)) begin
                n_fail++;
                $display("FAIL rand_rreq got %h want %h", obs_rreq_addr, line_addr(tag, idx));
            end
            n_checks++;
            if (ram_mem[idx] !== beats || obs_fill_cnt != 1) begin
                n_fail++;
                $display("FAIL rand_line got %h n=%0d want %h n=1", ram_mem[idx], obs_fill_cnt,
                         beats);
            end
            n_checks++;
            if (obs_done_cyc - obs_acc_cyc != 7) begin
                n_fail++;
                $display("FAIL rand_latency got %0d want 7", obs_done_cyc - obs_acc_cyc);
            end
        end
    endtask

    task automatic test_dirty_miss();
        logic [TAG_BITS-1:0] tag;
        logic [127:0] beats;
        tag = rnd_tag(); beats = rnd_line();
        ram_mem[2] = 128'h00000044_00000033_00000022_00000011;
        drive_miss(6'd2, tag, 2'd1, 1'b1, 22'h7, beats, 4, 0, 1'b0, 1'b0, -1);
        n_checks++;
        if (obs_wreq_addr !== 32'h0000_1C20 || obs_wreq_cnt != 1) begin
            n_fail++;
            $display("FAIL dirty_wreq got %h x%0d want 00001c20 x1", obs_wreq_addr, obs_wreq_cnt);
        end
        n_checks++;
        if (obs_wbeat.size() != 4) begin
            n_fail++; $display("FAIL dirty_nbeats got %0d want 4", obs_wbeat.size());
        end
        for (int i = 0; i < obs_wbeat.size() && i < 4; i++) begin
            n_checks++;
            if (obs_wbeat[i] !== 32'h11 * 32'(i + 1) || obs_wlast[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL dirty_beat%0d got %h last=%b want %h last=%b", i, obs_wbeat[i],
                         obs_wlast[i], 32'h11 * 32'(i + 1), i == 3);
            end
        end
        n_checks++;
        if (obs_rreq_addr !== line_addr(tag, 6'd2) || obs_rreq_wbeats != 4) begin
            n_fail++;
            $display("FAIL dirty_rreq got %h after %0d beats want %h after 4", obs_rreq_addr,
                     obs_rreq_wbeats, line_addr(tag, 6'd2));
        end
        n_checks++;
        if (ram_mem[2] !== beats || obs_done_cyc - obs_acc_cyc != 12) begin
            n_fail++;
            $display("FAIL dirty_fill got %h lat=%0d want %h lat=12", ram_mem[2],
                     obs_done_cyc - obs_acc_cyc, beats);
        end
    endtask

    task automatic test_backpressure();
        for (int it = 0; it < 3; it++) begin
            logic [IDX_BITS-1:0] idx;
            logic [TAG_BITS-1:0] tag, vtag;
            logic [127:0] victim, beats;
            idx = rnd_idx(); tag = rnd_tag(); vtag = rnd_tag();
            victim = rnd_line(); beats = rnd_line();
            ram_mem[idx] = victim;
            drive_miss(idx, tag, 2'd0, 1'b1, vtag, beats, 4, 3, 1'b1, 1'b0, -1);
            n_checks++;
            if (obs_timeout || obs_unstable != 0) begin
                n_fail++;
                $display("FAIL bp_stable got timeout=%b unstable=%0d want 0 0", obs_timeout,
                         obs_unstable);
            end
            n_checks++;
            if (obs_wbeat.size() != 4 || obs_wreq_addr !== line_addr(vtag, idx)) begin
                n_fail++;
                $display("FAIL bp_wb got n=%0d addr=%h want n=4 addr=%h", obs_wbeat.size(),
                         obs_wreq_addr, line_addr(vtag, idx));
            end
            for (int i = 0; i < obs_wbeat.size() && i < 4; i++) begin
                n_checks++;
                if (obs_wbeat[i] !== victim[32*i +: 32]) begin
                    n_fail++;
                    $display("FAIL bp_beat%0d got %h want %h", i, obs_wbeat[i],
                             victim[32*i +: 32]);
                end
            end
            n_checks++;
            if (ram_mem[idx] !== beats || obs_rreq_addr !== line_addr(tag, idx)) begin
                n_fail++;
                $display("FAIL bp_fill got %h rreq=%h want %h rreq=%h", ram_mem[idx],
                         obs_rreq_addr, beats, line_addr(tag, idx));
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [IDX_BITS-1:0] idx;
        logic [127:0] sentinel, beats;
        idx = rnd_idx(); sentinel = rnd_line(); beats = rnd_line();
        ram_mem[idx] = sentinel;
        drive_miss(idx, rnd_tag(), 2'd0, 1'b0, '0, beats, 4, 0, 1'b0, 1'b0, 2);
        @(negedge clk);
        #1;
        n_checks++;
        if (miss_ready !== 1'b1 || mreq_valid !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_idle got ready=%b mreq=%b done=%b want 1 0 0", miss_ready,
                     mreq_valid, done);
        end
        n_checks++;
        if (ram_strobe !== 16'h0 || obs_fill_cnt != 0 || ram_mem[idx] !== sentinel) begin
            n_fail++;
            $display("FAIL rst_mid_nowrite got strb=%h fills=%0d want 0 0", ram_strobe,
                     obs_fill_cnt);
        end
        reset = 1'b0;
        // A fresh miss after the abort must start from beat slot 0.
        idx = rnd_idx(); beats = rnd_line();
        drive_miss(idx, rnd_tag(), 2'd0, 1'b0, '0, beats, 4, 0, 1'b0, 1'b0, -1);
        n_checks++;
        if (ram_mem[idx] !== beats) begin
            n_fail++; $display("FAIL rst_mid_recover got %h want %h", ram_mem[idx], beats);
        end
    endtask

    task automatic test_early_last();
        logic [IDX_BITS-1:0] idx;
        logic [127:0] beats;
        idx = rnd_idx(); beats = rnd_line();
        drive_miss(idx, rnd_tag(), 2'd0, 1'b0, '0, beats, 2, 0, 1'b0, 1'b0, -1);
        n_checks++;
        if (obs_timeout || obs_fill_cnt != 1 || obs_done_cnt != 1) begin
            n_fail++;
            $display("FAIL early_fill got fills=%0d done=%0d want 1 1", obs_fill_cnt,
                     obs_done_cnt);
        end
        n_checks++;
        if (obs_fill_data !== expect_line(beats, 2)) begin
            n_fail++;
            $display("FAIL early_wdata got %h want %h", obs_fill_data, expect_line(beats, 2));
        end
    endtask

    task automatic test_ignore_busy();
        logic [IDX_BITS-1:0] idx;
        logic [TAG_BITS-1:0] tag;
        logic [127:0] beats;
        idx = rnd_idx(); tag = rnd_tag(); beats = rnd_line();
        drive_miss(idx, tag, 2'd0, 1'b0, '0, beats, 4, 0, 1'b1, 1'b1, -1);
        n_checks++;
        if (obs_accepts != 1) begin
            n_fail++; $display("FAIL busy_accepts got %0d want 1", obs_accepts);
        end
        n_checks++;
        if (obs_rreq_addr !== line_addr(tag, idx) || obs_fill_addr !== idx) begin
            n_fail++;
            $display("FAIL busy_fields got rreq=%h fill=%0d want %h %0d", obs_rreq_addr,
                     obs_fill_addr, line_addr(tag, idx), idx);
        end
    endtask

`ifdef DCACHE_REFILL_BYPASS_EN
    task automatic test_bypass();
        for (int w = 0; w < 4; w++) begin
            logic [127:0] beats;
            logic [1:0] word;
            beats = rnd_line();
            word  = 2'((w + 2) % 4);
            drive_miss(rnd_idx(), rnd_tag(), word, 1'($urandom_range(0, 1)), rnd_tag(), beats, 4,
                       0, w[0], 1'b0, -1);
            n_checks++;
            if (obs_byp_cnt != 1 || obs_byp_beat != int'(word)) begin
                n_fail++;
                $display("FAIL byp_count got n=%0d beat=%0d want 1 %0d", obs_byp_cnt,
                         obs_byp_beat, word);
            end
            n_checks++;
            if (obs_byp_data !== beats[32*word +: 32]) begin
                n_fail++;
                $display("FAIL byp_data got %h want %h", obs_byp_data, beats[32*word +: 32]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_miss();
        test_clean_random();
        test_dirty_miss();
        test_backpressure();
        test_early_last();
        test_reset_mid_read();
        test_ignore_busy();
`ifdef DCACHE_REFILL_BYPASS_EN
        test_bypass();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
